// File: rtl/n64_controller_responder.sv
`default_nettype none
// ============================================================================
//  Module   : n64_controller_responder
//  Brief    : Device-side N64 one-wire responder; decodes console commands and
//             replies with the status frame or the 32-bit button word.
//  Revision : 1.0  initial release
// ============================================================================
module n64_controller_responder #(
  parameter int US_CYCLES    = 100,
  parameter int REPLY_GAP_US = 2,
  parameter int TIMEOUT_US   = 6
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         fab_pin,
  input  logic [31:0] button_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        reset_cmd,
  output logic        rx_error,
  output logic        busy
);

  localparam logic [15:0] c_t1  = 16'(US_CYCLES);
  localparam logic [15:0] c_t2  = 16'(2 * US_CYCLES);
  localparam logic [15:0] c_t3  = 16'(3 * US_CYCLES);
  localparam logic [15:0] c_t4  = 16'(4 * US_CYCLES);
  localparam logic [15:0] c_gap = 16'(REPLY_GAP_US * US_CYCLES);
  localparam logic [15:0] c_tmo = 16'(TIMEOUT_US * US_CYCLES);
  localparam logic [31:0] c_status_frame = {8'h05, 8'h00, 8'h02, 8'h00};

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RX_LOW    = 4'd1,
    S_RX_HIGH   = 4'd2,
    S_WAIT_HIGH = 4'd3,
    S_DECODE    = 4'd4,
    S_GAP       = 4'd5,
    S_TX_LOW    = 4'd6,
    S_TX_HIGH   = 4'd7,
    S_TX_STOP   = 4'd8,
    S_GUARD     = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        sync1_q, sync2_q, hist_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic [5:0]  tx_bits_q, tx_bits_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        reset_cmd_q, reset_cmd_d;
  logic        rx_error_q, rx_error_d;
  logic        drive_q;
  logic        busy_q;

  logic        line_fall;
  logic        line_rise;
  logic [15:0] tx_low_len;
  logic [15:0] tx_high_len;

  assign line_fall   = hist_q & ~sync2_q;
  assign line_rise   = ~hist_q & sync2_q;
  assign tx_low_len  = tx_shift_q[31] ? c_t1 : c_t3;
  assign tx_high_len = c_t4 - tx_low_len;

  // Open-collector output: only ever pulls low.
  assign fab_pin   = drive_q ? 1'b0 : 1'bz;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign reset_cmd = reset_cmd_q;
  assign rx_error  = rx_error_q;
  assign busy      = busy_q;

  // Synchronizer resets high so an idle line never reads as a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= fab_pin;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (state_d != state_q) begin
      cnt_q <= 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      rx_shift_q  <= 8'd0;
      tx_shift_q  <= 32'd0;
      tx_bits_q   <= 6'd0;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      reset_cmd_q <= 1'b0;
      rx_error_q  <= 1'b0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_bits_q   <= tx_bits_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      reset_cmd_q <= reset_cmd_d;
      rx_error_q  <= rx_error_d;
      drive_q     <= (state_d == S_TX_LOW) || (state_d == S_TX_STOP);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_bits_d   = tx_bits_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    reset_cmd_d = 1'b0;
    rx_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (line_fall) begin
          state_d   = S_RX_LOW;
          bit_cnt_d = 4'd0;
        end
      end

      S_RX_LOW: begin
        if (cnt_q > c_tmo) begin
          rx_error_d = 1'b1;
          state_d    = S_WAIT_HIGH;
        end else if (line_rise) begin
          if (bit_cnt_q < 4'd8) begin
            // Short low pulse encodes a '1'.
            rx_shift_d = {rx_shift_q[6:0], (cnt_q < c_t2)};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            state_d    = S_RX_HIGH;
          end else begin
            state_d = S_DECODE;
          end
        end
      end

      S_RX_HIGH: begin
        if (line_fall) begin
          state_d = S_RX_LOW;
        end else if (cnt_q > c_tmo) begin
          rx_error_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_WAIT_HIGH: begin
        if (sync2_q) begin
          state_d = S_IDLE;
        end
      end

      S_DECODE: begin
        cmd_byte_d  = rx_shift_q;
        cmd_valid_d = 1'b1;
        case (rx_shift_q)
          8'h00, 8'hFF: begin
            tx_shift_d  = c_status_frame;
            tx_bits_d   = 6'd24;
            reset_cmd_d = (rx_shift_q == 8'hFF);
            state_d     = S_GAP;
          end
          8'h01: begin
            tx_shift_d = button_data;
            tx_bits_d  = 6'd32;
            state_d    = S_GAP;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_GAP: begin
        if (cnt_q == c_gap - 16'd1) begin
          state_d = S_TX_LOW;
        end
      end

      S_TX_LOW: begin
        if (cnt_q == tx_low_len - 16'd1) begin
          state_d = S_TX_HIGH;
        end
      end

      S_TX_HIGH: begin
        if (cnt_q == tx_high_len - 16'd1) begin
          tx_shift_d = {tx_shift_q[30:0], 1'b0};
          tx_bits_d  = tx_bits_q - 6'd1;
          state_d    = (tx_bits_q != 6'd1) ? S_TX_LOW : S_TX_STOP;
        end
      end

      S_TX_STOP: begin
        if (cnt_q == c_t2 - 16'd1) begin
          state_d = S_GUARD;
        end
      end

      // Our own release edge is still in the synchronizer; let it drain.
      S_GUARD: begin
        if (cnt_q == c_t2 - 16'd1) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_controller_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_controller_responder
//  Brief    : Directed console model and reply decoder for the N64 responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_n64_controller_responder;

  // Shorter microsecond keeps the run compact; all timings scale with it.
  localparam int US        = 50;
  localparam int EXP_LAT   = 2 * US;   // cmd_valid shows in the first GAP cycle
  localparam int EXP_PER   = 4 * US;
  localparam int EXP_STOP  = 2 * US;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] button_data = 32'h0;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, reset_cmd, rx_error, busy;
  logic        con_drive = 1'b0;
  wire         fab_pin;

  pullup (fab_pin);
  assign fab_pin = con_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  n64_controller_responder #(
    .US_CYCLES(US), .REPLY_GAP_US(2), .TIMEOUT_US(6)
  ) dut (
    .clk(clk), .reset(reset), .fab_pin(fab_pin), .button_data(button_data),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .reset_cmd(reset_cmd),
    .rx_error(rx_error), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0, rcmd_cnt = 0, coinc_cnt = 0, err_cnt = 0;
  logic [7:0] last_cmd = 8'h00;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      valid_cnt++;
      last_cmd = cmd_byte;
    end
    if (reset_cmd === 1'b1) begin
      rcmd_cnt++;
      if (cmd_valid === 1'b1) coinc_cnt++;
    end
    if (rx_error === 1'b1) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic con_bit(input logic b);
    con_drive = 1'b1;
    wait_cycles(b ? US : 3 * US);
    con_drive = 1'b0;
    wait_cycles(b ? 3 * US : US);
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    for (int i = 7; i >= 0; i--) con_bit(cmd[i]);
    con_drive = 1'b1;
    wait_cycles(US);
    con_drive = 1'b0;
  endtask

  task automatic get_reply(input int nbits, output logic [31:0] data, output int lat,
                           output int period, output int stop_low);
    int t, low, high;
    data = '0; lat = -1; period = -1; stop_low = -1;
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_valid !== 1'b1 && t < 50);
    if (cmd_valid !== 1'b1) return;
    button_data = 32'hDEAD_BEEF;
    lat = 0;
    do begin @(negedge clk); lat++; end while (fab_pin !== 1'b0 && lat < 1000);
    if (fab_pin !== 1'b0) return;
    for (int i = 0; i < nbits; i++) begin
      low = 1;
      @(negedge clk);
      while (fab_pin === 1'b0 && low < 1000) begin low++; @(negedge clk); end
      high = 1;
      @(negedge clk);
      while (fab_pin !== 1'b0 && high < 1000) begin high++; @(negedge clk); end
      data = {data[30:0], (low < 2 * US)};
      if (i == 0) period = low + high;
    end
    stop_low = 1;
    @(negedge clk);
    while (fab_pin === 1'b0 && stop_low < 1000) begin stop_low++; @(negedge clk); end
  endtask

  task automatic do_cmd_reply(input string tag, input logic [7:0] cmd, input int nbits,
                              input logic [31:0] exp, input int exp_rc);
    int v0, r0, c0, e0, lat, per, stp;
    logic [31:0] data;
    v0 = valid_cnt; r0 = rcmd_cnt; c0 = coinc_cnt; e0 = err_cnt;
    send_cmd(cmd);
    get_reply(nbits, data, lat, per, stp);
    wait_cycles(5 * US);
    check_eq({tag, "_valid_pulses"}, valid_cnt - v0, 1);
    check_eq({tag, "_cmd_byte"}, last_cmd, cmd);
    check_eq({tag, "_reset_cmd"}, rcmd_cnt - r0, exp_rc);
    check_eq({tag, "_reset_coincident"}, coinc_cnt - c0, exp_rc);
    check_eq({tag, "_latency"}, lat, EXP_LAT);
    check_eq({tag, "_bit_period"}, per, EXP_PER);
    check_eq({tag, "_data"}, data, exp);
    check_eq({tag, "_stop_low"}, stp, EXP_STOP);
    check_eq({tag, "_no_error"}, err_cnt - e0, 0);
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_released"}, fab_pin, 1);
  endtask

  initial begin
    int v0, e0, t, falls, lows;
    logic prev;

    wait_cycles(5);
    check_eq("rst_cmd_byte", cmd_byte, 8'h00);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_reset_cmd", reset_cmd, 0);
    check_eq("rst_rx_error", rx_error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pin", fab_pin, 1);
    reset = 1'b0;
    wait_cycles(20);

    button_data = 32'h8000_1234;
    do_cmd_reply("poll", 8'h01, 32, 32'h8000_1234, 0);
    do_cmd_reply("status", 8'h00, 24, 32'h0005_0002, 0);
    do_cmd_reply("reset", 8'hFF, 24, 32'h0005_0002, 1);

    // Unknown command: decoded, no reply.
    v0 = valid_cnt;
    send_cmd(8'h42);
    check_eq("unk_busy_in_frame", busy, 1);
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_valid !== 1'b1 && t < 50);
    check_eq("unk_busy_after_decode", busy, 0);
    lows = 0;
    repeat (10 * US) begin @(negedge clk); if (fab_pin !== 1'b1) lows++; end
    check_eq("unk_pin_stays_high", lows, 0);
    check_eq("unk_valid_pulses", valid_cnt - v0, 1);
    check_eq("unk_cmd_byte", last_cmd, 8'h42);

    // Four bits then the line stays high past the timeout.
    e0 = err_cnt; v0 = valid_cnt;
    con_bit(1'b1); con_bit(1'b0); con_bit(1'b1); con_bit(1'b0);
    wait_cycles(6 * US - 10 - US);
    check_eq("hi_tmo_not_early", err_cnt - e0, 0);
    wait_cycles(US + 10);
    check_eq("hi_tmo_error", err_cnt - e0, 1);
    check_eq("hi_tmo_idle", busy, 0);
    check_eq("hi_tmo_no_valid", valid_cnt - v0, 0);
    wait_cycles(US);
    button_data = 32'hA5C3_0F01;
    do_cmd_reply("after_tmo", 8'h01, 32, 32'hA5C3_0F01, 0);

    // Line held low for 10 us.
    e0 = err_cnt; v0 = valid_cnt;
    con_drive = 1'b1;
    wait_cycles(10 * US);
    check_eq("lo_tmo_error", err_cnt - e0, 1);
    check_eq("lo_tmo_wait_high", busy, 1);
    con_drive = 1'b0;
    wait_cycles(10);
    check_eq("lo_tmo_idle", busy, 0);
    check_eq("lo_tmo_no_valid", valid_cnt - v0, 0);
    wait_cycles(US);

    // Reset in the middle of reply bit 10.
    button_data = 32'h1234_5678;
    send_cmd(8'h01);
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_valid !== 1'b1 && t < 50);
    falls = 0; prev = 1'b1; t = 0;
    while (falls < 11 && t < 20000) begin
      @(negedge clk); t++;
      if (prev === 1'b1 && fab_pin === 1'b0) falls++;
      prev = fab_pin;
    end
    check_eq("mid_tx_falls", falls, 11);
    wait_cycles(US / 2);
    check_eq("mid_tx_pin_low", fab_pin, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_pin", fab_pin, 1);
    check_eq("mid_rst_cmd_byte", cmd_byte, 8'h00);
    check_eq("mid_rst_cmd_valid", cmd_valid, 0);
    check_eq("mid_rst_reset_cmd", reset_cmd, 0);
    check_eq("mid_rst_rx_error", rx_error, 0);
    check_eq("mid_rst_busy", busy, 0);
    reset = 1'b0;
    wait_cycles(20);
    do_cmd_reply("after_rst", 8'h00, 24, 32'h0005_0002, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
